// File: rtl/axi4_lite_read_arbiter.sv
// Two-master round-robin arbiter for the AXI4-Lite read path (AR + R) of a single slave.
// One read outstanding at a time: the grant is held from address acceptance until the R handshake.
module axi4_lite_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] araddr_m1,
  input  logic [2:0]            arprot_m1,
  input  logic                  arvalid_m1,
  output logic                  arready_m1,
  output logic [DATA_WIDTH-1:0] rdata_m1,
  output logic [1:0]            rresp_m1,
  output logic                  rvalid_m1,
  input  logic                  rready_m1,
  input  logic [ADDR_WIDTH-1:0] araddr_m2,
  input  logic [2:0]            arprot_m2,
  input  logic                  arvalid_m2,
  output logic                  arready_m2,
  output logic [DATA_WIDTH-1:0] rdata_m2,
  output logic [1:0]            rresp_m2,
  output logic                  rvalid_m2,
  input  logic                  rready_m2,
  output logic [ADDR_WIDTH-1:0] araddr_s,
  output logic [2:0]            arprot_s,
  output logic                  arvalid_s,
  input  logic                  arready_s,
  input  logic [DATA_WIDTH-1:0] rdata_s,
  input  logic [1:0]            rresp_s,
  input  logic                  rvalid_s,
  output logic                  rready_s,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M1   = 2'b01;
  localparam logic [1:0] GNT_M2   = 2'b10;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_q, last_d;

  // State, grant and round-robin history registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      grant_q <= GNT_NONE;
      last_q  <= GNT_M2;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant through ADDR and DATA
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (arvalid_m1 && arvalid_m2) begin
          grant_d = (last_q == GNT_M1) ? GNT_M2 : GNT_M1;
          state_d = S_ADDR;
        end else if (arvalid_m1) begin
          grant_d = GNT_M1;
          state_d = S_ADDR;
        end else if (arvalid_m2) begin
          grant_d = GNT_M2;
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (arvalid_s && arready_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (rvalid_s && rready_s) begin
          state_d = S_IDLE;
          last_d  = grant_q;
          grant_d = GNT_NONE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // Output muxes: only the granted master sees traffic, everything else is driven to zero
  always_comb begin
    araddr_s   = '0;
    arprot_s   = 3'b000;
    arvalid_s  = 1'b0;
    rready_s   = 1'b0;
    arready_m1 = 1'b0;
    rdata_m1   = '0;
    rresp_m1   = 2'b00;
    rvalid_m1  = 1'b0;
    arready_m2 = 1'b0;
    rdata_m2   = '0;
    rresp_m2   = 2'b00;
    rvalid_m2  = 1'b0;
    case (state_q)
      S_ADDR: begin
        if (grant_q[0]) begin
          araddr_s   = araddr_m1;
          arprot_s   = arprot_m1;
          arvalid_s  = arvalid_m1;
          arready_m1 = arready_s;
        end else if (grant_q[1]) begin
          araddr_s   = araddr_m2;
          arprot_s   = arprot_m2;
          arvalid_s  = arvalid_m2;
          arready_m2 = arready_s;
        end else begin
          arvalid_s = 1'b0;
        end
      end
      S_DATA: begin
        if (grant_q[0]) begin
          rdata_m1  = rdata_s;
          rresp_m1  = rresp_s;
          rvalid_m1 = rvalid_s;
          rready_s  = rready_m1;
        end else if (grant_q[1]) begin
          rdata_m2  = rdata_s;
          rresp_m2  = rresp_s;
          rvalid_m2 = rvalid_s;
          rready_s  = rready_m2;
        end else begin
          rready_s = 1'b0;
        end
      end
      default: begin
        rready_s = 1'b0;
      end
    endcase
  end

  assign grant = grant_q;

endmodule
